// File: rtl/gba_bw_bram_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gba_bw_pkg
//  Description : Shared constants and FSM state type for the BW image
//                block-RAM reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package gba_bw_pkg;

    localparam int IMG_BYTES    = 512;
    localparam int ADDR_W       = 9;
    localparam int PIX_PER_BYTE = 8;
    localparam int PIXELS       = IMG_BYTES * PIX_PER_BYTE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gba_bw_bram_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : gba_bw_bram_reader_if
//  Description : Control, memory-read and pixel-stream signals of the BW
//                image reader. master = reader side, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gba_bw_bram_reader_if #(
    parameter int ADDR_W = gba_bw_pkg::ADDR_W
) ();

    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_data;
    logic              mem_valid;
    logic              pix_valid;
    logic              pix_data;
    logic              pix_ready;
    logic              pix_last;

    modport master (
        input  start, mem_data, mem_valid, pix_ready,
        output busy, done, mem_rd_en, mem_rd_addr, pix_valid, pix_data, pix_last
    );

    modport slave (
        output start, mem_data, mem_valid, pix_ready,
        input  busy, done, mem_rd_en, mem_rd_addr, pix_valid, pix_data, pix_last
    );

endinterface
`default_nettype wire

// File: rtl/gba_bw_pixel_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : gba_bw_pixel_unpacker
//  Description : Byte-in / pixel-out converter. A shift register emits one
//                bit per accepted pixel; a one-byte prefetch register hides
//                the memory latency so a full byte stream has no bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module gba_bw_pixel_unpacker #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_data,
    input  logic       out_ready
);
    import gba_bw_pkg::*;

    localparam logic [3:0] c_full_bits = 4'(PIX_PER_BYTE);

    logic [7:0] r_shift;
    logic [7:0] r_pf;
    logic       r_pf_full;
    logic [3:0] r_bits;      // pixels still to emit from r_shift

    logic       w_fire;
    logic       w_last_bit;
    logic [7:0] w_shift_next;

    assign out_valid    = (r_bits != 4'd0);
    assign out_data     = MSB_FIRST ? r_shift[7] : r_shift[0];
    assign w_fire       = out_valid && out_ready;
    assign w_last_bit   = w_fire && (r_bits == 4'd1);
    // Room for one more byte once the prefetch slot is free or freeing now.
    assign in_ready     = !r_pf_full || w_last_bit;
    assign w_shift_next = MSB_FIRST ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};

    // Shift/prefetch datapath: incoming bytes go straight to the shift
    // register when it is (becoming) empty, otherwise into the prefetch slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= 8'd0;
            r_pf      <= 8'd0;
            r_pf_full <= 1'b0;
            r_bits    <= 4'd0;
        end else if (in_valid) begin
            if ((r_bits == 4'd0) || w_last_bit) begin
                // An older prefetched byte must go first to keep byte order.
                if (r_pf_full) begin
                    r_shift <= r_pf;
                    r_pf    <= in_data;
                end else begin
                    r_shift <= in_data;
                end
                r_bits <= c_full_bits;
            end else begin
                r_pf      <= in_data;
                r_pf_full <= 1'b1;
                if (w_fire) begin
                    r_shift <= w_shift_next;
                    r_bits  <= r_bits - 4'd1;
                end
            end
        end else if (w_last_bit) begin
            if (r_pf_full) begin
                r_shift   <= r_pf;
                r_pf_full <= 1'b0;
                r_bits    <= c_full_bits;
            end else begin
                r_bits <= 4'd0;
            end
        end else if (w_fire) begin
            r_shift <= w_shift_next;
            r_bits  <= r_bits - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gba_bw_bram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : gba_bw_bram_reader
//  Description : Streams one frame of a 1-bit-per-pixel image from block RAM
//                as a valid/ready pixel stream, one read outstanding at most.
//  Revision    : 1.0 - initial release
// ============================================================================
module gba_bw_bram_reader #(
    parameter int DEPTH     = gba_bw_pkg::IMG_BYTES,
    parameter int ADDR_W    = gba_bw_pkg::ADDR_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    gba_bw_bram_reader_if.master  bus
);
    import gba_bw_pkg::*;

    localparam int                c_pix_total = DEPTH * PIX_PER_BYTE;
    localparam int                c_cnt_w     = (c_pix_total > 1) ? $clog2(c_pix_total) : 1;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_last_pix = c_cnt_w'(c_pix_total - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_cnt_w-1:0]  r_pix_cnt;
    logic                r_outstanding;
    logic                r_done;

    logic                w_rd_en;
    logic                w_resp;
    logic                w_in_ready;
    logic                w_unp_valid;
    logic                w_unp_data;
    logic                w_pix_fire;
    logic                w_pix_last;
    logic                w_last_fire;

    // Responses are only meaningful while a read of ours is in flight.
    assign w_resp      = bus.mem_valid && r_outstanding;
    assign w_pix_fire  = w_unp_valid && bus.pix_ready;
    assign w_pix_last  = w_unp_valid && (r_pix_cnt == c_last_pix);
    assign w_last_fire = w_pix_fire && w_pix_last;

    gba_bw_pixel_unpacker #(
        .MSB_FIRST (MSB_FIRST)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_resp),
        .in_data   (bus.mem_data),
        .in_ready  (w_in_ready),
        .out_valid (w_unp_valid),
        .out_data  (w_unp_data),
        .out_ready (bus.pix_ready)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and read-issue decode; a start on the done cycle is dropped.
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !r_done) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_rd_en = !r_outstanding && w_in_ready;
                if (w_rd_en && (r_addr == c_last_addr)) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_last_fire) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Address, outstanding-read, pixel counters and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_outstanding <= 1'b0;
            r_pix_cnt     <= '0;
            r_done        <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_addr        <= (r_addr == c_last_addr) ? '0 : r_addr + ADDR_W'(1);
                r_outstanding <= 1'b1;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end
            if (w_pix_fire) begin
                r_pix_cnt <= (r_pix_cnt == c_last_pix) ? '0 : r_pix_cnt + c_cnt_w'(1);
            end
            r_done <= w_last_fire;
        end
    end

    // Outputs are forced low for the whole reset cycle, not just after it.
    assign bus.busy        = (r_state != ST_IDLE) && !rst;
    assign bus.done        = r_done && !rst;
    assign bus.mem_rd_en   = w_rd_en && !rst;
    assign bus.mem_rd_addr = rst ? '0 : r_addr;
    assign bus.pix_valid   = w_unp_valid && !rst;
    assign bus.pix_data    = w_unp_data && !rst;
    assign bus.pix_last    = w_pix_last && !rst;

endmodule
`default_nettype wire

// File: tb/tb_gba_bw_bram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gba_bw_bram_reader
//  Description : Scoreboard bench for gba_bw_bram_reader. Two instances
//                (MSB-first and LSB-first) share stimulus and image memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gba_bw_bram_reader;
    import gba_bw_pkg::*;

    typedef struct packed {
        logic d;
        logic l;
    } pix_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic start     = 1'b0;
    logic pix_ready = 1'b1;
    logic inject    = 1'b0;
    int   ready_mode = 0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem [0:IMG_BYTES-1];
    pix_t q0[$];
    pix_t q1[$];
    logic got0 [0:PIXELS-1];
    logic got1 [0:PIXELS-1];
    int   idx [2];
    int   exp_addr [2];
    logic stall_prev [2];
    logic pd_prev [2];
    logic pl_prev [2];
    logic lhs_prev [2];

    gba_bw_bram_reader_if #(.ADDR_W(ADDR_W)) bus_a ();
    gba_bw_bram_reader_if #(.ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.start     = start;
    assign bus_b.start     = start;
    assign bus_a.pix_ready = pix_ready;
    assign bus_b.pix_ready = pix_ready;

    gba_bw_bram_reader #(.DEPTH(IMG_BYTES), .ADDR_W(ADDR_W), .MSB_FIRST(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    gba_bw_bram_reader #(.DEPTH(IMG_BYTES), .ADDR_W(ADDR_W), .MSB_FIRST(1'b0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM model: one-cycle read latency; inject forces a stray response.
    always @(posedge clk) begin
        bus_a.mem_valid <= bus_a.mem_rd_en | inject;
        bus_a.mem_data  <= inject ? 8'h00 : mem[bus_a.mem_rd_addr];
        bus_b.mem_valid <= bus_b.mem_rd_en | inject;
        bus_b.mem_data  <= inject ? 8'h00 : mem[bus_b.mem_rd_addr];
    end

    // Downstream ready: always high, or about 30% duty.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(99) < 30);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream for one frame: pixel i is bit (i mod 8) of byte i/8,
    // counted from bit 7 when MSB-first and from bit 0 otherwise.
    task automatic push_frame();
        pix_t e;
        logic [7:0] b;
        for (int i = 0; i < PIXELS; i++) begin
            b   = mem[i / PIX_PER_BYTE];
            e.l = (i == PIXELS - 1);
            e.d = b[7 - (i % PIX_PER_BYTE)];
            q0.push_back(e);
            e.d = b[i % PIX_PER_BYTE];
            q1.push_back(e);
        end
    endtask

    task automatic mon(input int k, input logic pv, input logic pd, input logic pl,
                       input logic pr, input logic re, input logic [ADDR_W-1:0] ad,
                       input logic dn, input logic bz);
        pix_t e;
        bit   have;
        if (rst) begin
            idx[k] = 0; exp_addr[k] = 0; stall_prev[k] = 0; lhs_prev[k] = 0;
            return;
        end
        if (stall_prev[k]) begin
            chk($sformatf("hold_valid%0d", k), int'(pv), 1);
            chk($sformatf("hold_data%0d", k), int'(pd), int'(pd_prev[k]));
            chk($sformatf("hold_last%0d", k), int'(pl), int'(pl_prev[k]));
        end
        if (pv && pr) begin
            have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                chk($sformatf("unexpected_pixel%0d", k), 1, 0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("pix_data%0d_idx%0d", k, idx[k]), int'(pd), int'(e.d));
                chk($sformatf("pix_last%0d_idx%0d", k, idx[k]), int'(pl), int'(e.l));
                if (idx[k] < PIXELS) begin
                    if (k == 0) got0[idx[k]] = pd;
                    else        got1[idx[k]] = pd;
                end
                idx[k] = e.l ? 0 : idx[k] + 1;
            end
        end
        if (re) begin
            chk($sformatf("rd_addr%0d", k), int'(ad), exp_addr[k]);
            exp_addr[k] = (exp_addr[k] + 1) % IMG_BYTES;
        end
        if (dn || lhs_prev[k]) chk($sformatf("done_timing%0d", k), int'(dn), int'(lhs_prev[k]));
        if (dn) chk($sformatf("busy_low_on_done%0d", k), int'(bz), 0);
        stall_prev[k] = pv && !pr;
        pd_prev[k]    = pd;
        pl_prev[k]    = pl;
        lhs_prev[k]   = pv && pr && pl;
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon(0, bus_a.pix_valid, bus_a.pix_data, bus_a.pix_last, bus_a.pix_ready,
            bus_a.mem_rd_en, bus_a.mem_rd_addr, bus_a.done, bus_a.busy);
        mon(1, bus_b.pix_valid, bus_b.pix_data, bus_b.pix_last, bus_b.pix_ready,
            bus_b.mem_rd_en, bus_b.mem_rd_addr, bus_b.done, bus_b.busy);
    end

    task automatic check_zero(input string tag);
        chk({tag, "_flags_a"}, int'({bus_a.busy, bus_a.done, bus_a.mem_rd_en,
                                     bus_a.pix_valid, bus_a.pix_data, bus_a.pix_last}), 0);
        chk({tag, "_addr_a"}, int'(bus_a.mem_rd_addr), 0);
        chk({tag, "_flags_b"}, int'({bus_b.busy, bus_b.done, bus_b.mem_rd_en,
                                     bus_b.pix_valid, bus_b.pix_data, bus_b.pix_last}), 0);
        chk({tag, "_addr_b"}, int'(bus_b.mem_rd_addr), 0);
    endtask

    task automatic check_window(input string tag);
        int exp_msb [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        int exp_lsb [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("%s_msb_pix%0d", tag, 720 + j), int'(got0[720 + j]), exp_msb[j]);
            chk($sformatf("%s_lsb_pix%0d", tag, 720 + j), int'(got1[720 + j]), exp_lsb[j]);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_a.done && n < budget);
        chk(name, int'(bus_a.done), 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        int bubbles;
        int n;
        int any;
        for (int i = 0; i < IMG_BYTES; i++) mem[i] = 8'hFF;
        mem[90] = 8'h1F;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk); #1 rst = 1'b0;

        // Frame 1: start in cycle 10, ready held high, exact latency.
        do begin @(posedge clk); #1; end while (cyc < 10);
        start = 1'b1;
        push_frame();
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("first_rd_en_T1", int'(bus_a.mem_rd_en), 1);
        chk("first_rd_addr", int'(bus_a.mem_rd_addr), 0);
        chk("busy_T1", int'(bus_a.busy), 1);
        @(negedge clk);
        chk("no_pix_T2", int'(bus_a.pix_valid), 0);
        @(negedge clk);
        chk("first_pix_T3", int'(bus_a.pix_valid), 1);
        bubbles = 0;
        for (int i = 1; i < PIXELS; i++) begin
            @(negedge clk);
            if (!bus_a.pix_valid) bubbles++;
        end
        chk("bubbles", bubbles, 0);
        @(negedge clk);
        chk("done_after_last", int'(bus_a.done), 1);
        chk("busy_on_done", int'(bus_a.busy), 0);
        chk("queue_empty_f1_a", q0.size(), 0);
        chk("queue_empty_f1_b", q1.size(), 0);
        check_window("f1");

        // Frame 2: same image, ready at ~30% duty.
        ready_mode = 1;
        push_frame();
        pulse_start();
        wait_done(20000, "done_f2");
        ready_mode = 0;
        chk("queue_empty_f2_a", q0.size(), 0);
        chk("queue_empty_f2_b", q1.size(), 0);
        check_window("f2");

        // Frame 3: reset just after the read of address 37, with a stray
        // response arriving the cycle after reset releases.
        push_frame();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_a.mem_rd_en && bus_a.mem_rd_addr == 9'd37) && n < 2000);
        chk("found_rd37", int'(bus_a.mem_rd_en && bus_a.mem_rd_addr == 9'd37), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        inject = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        check_zero("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        inject = 1'b0;
        @(negedge clk);
        check_zero("after_reset");
        any = 0;
        repeat (4) begin
            @(negedge clk);
            any |= int'(bus_a.pix_valid | bus_b.pix_valid | bus_a.busy);
        end
        chk("stale_resp_ignored", any, 0);
        push_frame();
        pulse_start();
        wait_done(6000, "done_f3");
        chk("queue_empty_f3_a", q0.size(), 0);
        chk("queue_empty_f3_b", q1.size(), 0);

        // Frame 4: random image, start re-pulsed mid-frame and on done.
        for (int i = 0; i < IMG_BYTES; i++) mem[i] = 8'($urandom);
        push_frame();
        pulse_start();
        repeat (1000) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_a.pix_valid && bus_a.pix_ready && bus_a.pix_last) && n < 6000);
        chk("found_last_f4", int'(bus_a.pix_valid && bus_a.pix_ready && bus_a.pix_last), 1);
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        chk("done_f4", int'(bus_a.done), 1);
        @(posedge clk); #1 start = 1'b0;
        any = 0;
        repeat (30) begin
            @(negedge clk);
            any |= int'(bus_a.busy | bus_a.mem_rd_en | bus_a.pix_valid |
                        bus_b.busy | bus_b.mem_rd_en | bus_b.pix_valid);
        end
        chk("idle_after_f4", any, 0);
        chk("queue_empty_f4_a", q0.size(), 0);
        chk("queue_empty_f4_b", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected summary before it", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gba_bw_bram_reader.md
GBA_BW_BRAM_READER -- requirements
Module: gba_bw_bram_reader

Interface
REQ-001 Parameter DEPTH, default 512, number of bytes per image block read per frame.
REQ-002 Parameter ADDR_W, default 9, width of the memory address.
REQ-003 Parameter MSB_FIRST, default 1: bit 7 of each byte is the first pixel emitted; when 0, bit 0 is first.
REQ-004 Port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous and active-high.
REQ-006 Port start  in  1  one-cycle request to stream one full frame.
REQ-007 Port busy  out  1  high from the cycle after start is accepted until done.
REQ-008 Port done  out  1  one-cycle pulse when the frame has completed.
REQ-009 Port mem_rd_en  out  1  read strobe to the BW image block RAM.
REQ-010 Port mem_rd_addr  out  ADDR_W  byte address to read.
REQ-011 Port mem_data  in  8  returned byte, valid when mem_valid is high.
REQ-012 Port mem_valid  in  1  high exactly one cycle after an accepted mem_rd_en.
REQ-013 Port pix_valid  out  1  pixel available.
REQ-014 Port pix_data  out  1  pixel value: 1 = white, 0 = black.
REQ-015 Port pix_ready  in  1  downstream accepts the pixel when pix_valid and pix_ready are both high.
REQ-016 Port pix_last  out  1  high with pix_valid on pixel DEPTH*8-1 only.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and FLUSH: IDLE->RUN on start; RUN->FLUSH after read DEPTH-1 is issued; FLUSH->IDLE on the last pixel handshake.
REQ-018 start SHALL be ignored in RUN and FLUSH, and no second frame is queued.
REQ-019 Reads SHALL be issued in ascending address order, 0 to DEPTH-1, each address exactly once per frame, with mem_rd_addr stable while mem_rd_en is high.
REQ-020 At most one read SHALL be outstanding; a new read SHALL be issued only when the prefetch register is empty or is being drained in the same cycle.
REQ-021 A returned byte SHALL load directly into the shift register if the register is empty or on its final bit being consumed; otherwise it SHALL load into the prefetch register.
REQ-022 If start is high in cycle T, the first mem_rd_en SHALL occur in T+1 and the first pix_valid in T+3.
REQ-023 With pix_ready held high, DEPTH*8 pixels SHALL be emitted on consecutive cycles with no bubble.
REQ-024 While pix_valid is high and pix_ready is low, pix_data and pix_last SHALL hold stable, and no byte SHALL be lost or reordered.
REQ-025 mem_valid SHALL be ignored when no read is outstanding, including in IDLE.
REQ-026 done SHALL pulse in the cycle after the pix_last handshake, with busy low in that same cycle.
REQ-027 A start arriving in the same cycle as done SHALL be ignored.
REQ-028 The pixel counter SHALL be log2(DEPTH*8) bits wide and SHALL wrap to 0 at frame end.

Reset
REQ-029 While rst is high: FSM = IDLE, and busy, done, mem_rd_en, pix_valid, pix_data and pix_last SHALL be 0.
REQ-030 While rst is high: mem_rd_addr SHALL be 0, and the counters, the prefetch-full flag and the outstanding flag SHALL be cleared.
REQ-031 rst SHALL dominate start, mem_valid and pix_ready in the same cycle.
REQ-032 A read response arriving in the cycle after reset releases SHALL be discarded.

Structure
REQ-033 Shared package gba_bw_pkg SHALL hold IMG_BYTES=512, ADDR_W=9, PIX_PER_BYTE=8 and PIXELS=4096.
REQ-034 One sub-module, gba_bw_pixel_unpacker, SHALL contain the shift register, prefetch register and bit counter, with a byte-in/pixel-out valid-ready interface.

Verification
REQ-035 Memory model is 512 bytes, all 0xFF except byte 90 = 0x1F; pix_ready held high; start pulsed in cycle 10 -> mem_rd_en in cycle 11, first pix_valid in cycle 13, 4096 contiguous pixels.
REQ-036 Same run -> pixels 720..727 are 0,0,0,1,1,1,1,1; all other pixels are 1; pix_last only on pixel 4095; done in the next cycle.
REQ-037 MSB_FIRST=0 with the same image -> pixels 720..727 are 1,1,1,1,1,0,0,0.
REQ-038 pix_ready toggling pseudo-randomly at 30% duty -> the pixel sequence is identical to REQ-036; never more than one read outstanding; addresses are strictly increasing.
REQ-039 rst asserted for 1 cycle immediately after the read of address 37 is issued -> all outputs are 0 in the following cycle; the stale mem_valid is ignored; a subsequent start streams from address 0.
REQ-040 start re-pulsed mid-frame and again on the done cycle -> both are ignored; exactly one frame is emitted and busy stays low afterwards.
